// File: rtl/ins_cache_ml.sv
// Direct-mapped instruction cache with a single outstanding DDR line fill.
// A miss requests one burst that covers the line, truncated at the end of the
// program. The burst is written in through a FIFO and the requested word is
// then returned from the line storage.
module ins_cache_ml #(
  parameter int ISA_WIDTH       = 30,
  parameter int OPCODE_WIDTH    = 4,
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int NUM_LINES       = 4,
  parameter int LINE_DEPTH      = 32,
  parameter int TOTAL_ISA_DEPTH = 100,
  parameter int ISA_BASE_ADDR   = 0,
  parameter int ADDR_SHIFT      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ins_req,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  input  logic                      flush,
  output logic                      ins_cache_rdy,
  output logic [ISA_WIDTH-1:0]      ins_to_apctrl,
  output logic [OPCODE_WIDTH-1:0]   ins_valid,
  output logic                      ins_end,
  output logic                      ins_read_req,
  input  logic                      ins_reading,
  output logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
  output logic [7:0]                ins_read_len,
  output logic                      rd_en_ddr_to_ic_fifo,
  input  logic [ISA_WIDTH+8:0]      ins_fifo_to_ic,
  input  logic                      ddr_to_ic_fifo_empty,
  output logic [15:0]               miss_cnt
);
  localparam int OFF_W = $clog2(LINE_DEPTH);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH_MEM - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, RESP} state_t;

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH_MEM-1:0] addr_q;
  logic [NUM_LINES-1:0]      valid;
  logic [TAG_W-1:0]          tags [NUM_LINES];
  logic [ISA_WIDTH-1:0]      mem  [NUM_LINES*LINE_DEPTH];
  logic [7:0]                fill_cnt;
  logic                      pop_d;       // a FIFO word was popped last cycle
  logic                      flush_pend;  // flush seen while the current fill was in flight

  // Address fields of the latched fetch
  logic [OFF_W-1:0]          off;
  logic [IDX_W-1:0]          idx;
  logic [TAG_W-1:0]          tag;
  logic [ADDR_WIDTH_MEM-1:0] line_base;
  logic [31:0]               base_w;
  logic                      in_range, hit;

  assign off       = addr_q[OFF_W-1:0];
  assign idx       = addr_q[OFF_W +: IDX_W];
  assign tag       = addr_q[ADDR_WIDTH_MEM-1 -: TAG_W];
  assign line_base = {addr_q[ADDR_WIDTH_MEM-1:OFF_W], {OFF_W{1'b0}}};
  assign base_w    = 32'(line_base);
  assign in_range  = 32'(addr_q) < TOTAL_ISA_DEPTH;
  // A flush in the lookup cycle forces a miss
  assign hit       = !flush && valid[idx] && (tags[idx] == tag);

  // FIFO word layout: {word, cnt, burst_valid}
  logic [ISA_WIDTH-1:0] f_word;
  logic [7:0]           f_cnt;
  logic                 f_bv;
  logic                 wr_fill, fill_last;

  assign f_word    = ins_fifo_to_ic[ISA_WIDTH+8:9];
  assign f_cnt     = ins_fifo_to_ic[8:1];
  assign f_bv      = ins_fifo_to_ic[0];
  assign wr_fill   = (state == FILL) && pop_d && f_bv && (f_cnt < ins_read_len);
  assign fill_last = wr_fill && ((fill_cnt + 8'd1) == ins_read_len);

  assign ins_cache_rdy = (state == IDLE);
  assign ins_read_addr = DDR_ADDR_WIDTH'(ISA_BASE_ADDR) +
                         (DDR_ADDR_WIDTH'(line_base) << ADDR_SHIFT);

  // Burst length: whole line, clipped at the end of the program
  always_comb begin
    ins_read_len = 8'd0;
    if (base_w >= TOTAL_ISA_DEPTH)
      ins_read_len = 8'd0;
    else if ((TOTAL_ISA_DEPTH - base_w) >= LINE_DEPTH)
      ins_read_len = 8'(LINE_DEPTH);
    else
      ins_read_len = 8'(TOTAL_ISA_DEPTH - base_w);
  end

  // Next-state and Moore/combinational outputs
  always_comb begin
    state_nxt            = state;
    ins_read_req         = 1'b0;
    rd_en_ddr_to_ic_fifo = 1'b0;
    ins_end              = 1'b0;
    ins_valid            = '0;
    ins_to_apctrl        = '0;
    case (state)
      IDLE:   if (ins_req) state_nxt = LOOKUP;
      LOOKUP: begin
        if (!in_range) begin
          ins_end   = 1'b1;
          state_nxt = IDLE;
        end else if (hit) begin
          state_nxt = RESP;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        ins_read_req = 1'b1;
        if (ins_reading) state_nxt = FILL;
      end
      FILL: begin
        rd_en_ddr_to_ic_fifo = !ddr_to_ic_fifo_empty && (fill_cnt != ins_read_len);
        if (fill_last) state_nxt = RESP;
      end
      RESP: begin
        ins_valid     = {OPCODE_WIDTH{1'b1}};
        ins_to_apctrl = mem[{idx, off}];
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, line bookkeeping and miss counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      valid      <= '0;
      miss_cnt   <= '0;
      fill_cnt   <= '0;
      pop_d      <= 1'b0;
      flush_pend <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) tags[i] <= '0;
    end else begin
      state <= state_nxt;
      pop_d <= rd_en_ddr_to_ic_fifo;
      if (state == IDLE && ins_req) addr_q <= addr_ins;
      if (state == LOOKUP && state_nxt == REQ) begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        valid[idx] <= 1'b0;
        fill_cnt   <= '0;
        flush_pend <= 1'b0;
      end
      if ((state == REQ || state == FILL) && flush) flush_pend <= 1'b1;
      if (wr_fill) fill_cnt <= fill_cnt + 8'd1;
      if (fill_last) begin
        tags[idx]  <= tag;
        valid[idx] <= !(flush_pend || flush);
      end
      if (flush) valid <= '0;
    end
  end

  // Line storage is not reset; valid bits gate its use
  always_ff @(posedge clk) begin
    if (wr_fill) mem[{idx, f_cnt[OFF_W-1:0]}] <= f_word;
  end
endmodule

// File: tb/tb_ins_cache_ml.sv
// Bench for ins_cache_ml: directed scenarios plus random fetches, checked
// against a line-level cache model and a queue-based DDR/FIFO model.
module tb_ins_cache_ml;
  localparam int IW  = 30;
  localparam int OW  = 4;
  localparam int AW  = 16;
  localparam int DW  = 28;
  localparam int NL  = 4;
  localparam int LD  = 32;
  localparam int TOT = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          ins_req;
  logic [AW-1:0] addr_ins;
  logic          flush;
  logic          ins_cache_rdy;
  logic [IW-1:0] ins_to_apctrl;
  logic [OW-1:0] ins_valid;
  logic          ins_end;
  logic          ins_read_req;
  logic          ins_reading;
  logic [DW-1:0] ins_read_addr;
  logic [7:0]    ins_read_len;
  logic          rd_en_ddr_to_ic_fifo;
  logic [IW+8:0] ins_fifo_to_ic;
  logic          ddr_to_ic_fifo_empty;
  logic [15:0]   miss_cnt;

  always #5 clk = ~clk;

  ins_cache_ml #(
    .ISA_WIDTH(IW), .OPCODE_WIDTH(OW), .ADDR_WIDTH_MEM(AW), .DDR_ADDR_WIDTH(DW),
    .NUM_LINES(NL), .LINE_DEPTH(LD), .TOTAL_ISA_DEPTH(TOT), .ISA_BASE_ADDR(0),
    .ADDR_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst), .ins_req(ins_req), .addr_ins(addr_ins), .flush(flush),
    .ins_cache_rdy(ins_cache_rdy), .ins_to_apctrl(ins_to_apctrl),
    .ins_valid(ins_valid), .ins_end(ins_end), .ins_read_req(ins_read_req),
    .ins_reading(ins_reading), .ins_read_addr(ins_read_addr),
    .ins_read_len(ins_read_len), .rd_en_ddr_to_ic_fifo(rd_en_ddr_to_ic_fifo),
    .ins_fifo_to_ic(ins_fifo_to_ic), .ddr_to_ic_fifo_empty(ddr_to_ic_fifo_empty),
    .miss_cnt(miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DDR-side FIFO model and the program image it serves
  logic [IW+8:0] q[$];
  logic [IW+8:0] pend[$];
  bit            pop_pend;
  logic [IW-1:0] prog [TOT];

  // Cache model: which program line each slot holds
  bit mv [NL];
  int mt [NL];
  int m_miss;

  // One clock: inputs are settled, the pop decision is taken before the
  // edge and the popped word shows on the FIFO output after it.
  task automatic step();
    ddr_to_ic_fifo_empty = (q.size() == 0);
    #1;
    pop_pend = rd_en_ddr_to_ic_fifo;
    @(negedge clk);
    if (pop_pend && q.size() > 0) ins_fifo_to_ic = q.pop_front();
    ddr_to_ic_fifo_empty = (q.size() == 0);
    #1;
  endtask

  task automatic build_burst(input int base, input int len);
    int perm[$];
    int j, t;
    pend.delete();
    for (int c = 0; c < len; c++) perm.push_back(c);
    for (int i = len - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    foreach (perm[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          pend.push_back({IW'($urandom), 8'($urandom), 1'b0});
        else
          pend.push_back({IW'($urandom), 8'($urandom_range(LD, 255)), 1'b1});
      end
      pend.push_back({prog[base + perm[i]], 8'(perm[i]), 1'b1});
    end
  endtask

  task automatic fetch(input int a, input bit inj_flush, input bit inj_rst);
    int line, tg, base, len, k, k_vld, pushed, cnt_end;
    bit oor, hit, got_req, accepted, flushed, done, bad_data;
    logic [DW-1:0] r_addr;
    logic [7:0]    r_len;
    logic [IW-1:0] r_word;
    logic [OW-1:0] r_vld;
    oor  = (a >= TOT);
    line = (a / LD) % NL;
    tg   = a / (LD * NL);
    base = (a / LD) * LD;
    len  = (TOT - base < LD) ? TOT - base : LD;
    hit  = !oor && mv[line] && (mt[line] == tg);
    k_vld = 0; pushed = 0; cnt_end = 0;
    got_req = 0; accepted = 0; flushed = 0; done = 0; bad_data = 0;
    r_addr = '0; r_len = '0; r_word = '0; r_vld = '0;

    chk("rdy_before", 64'(ins_cache_rdy), 64'd1);
    ins_req = 1'b1; addr_ins = AW'(a);
    step();
    ins_req = 1'b0;
    k = 1;
    while (!done && k < 600) begin
      if (ins_read_req) begin got_req = 1; r_addr = ins_read_addr; r_len = ins_read_len; end
      if (ins_end) cnt_end++;
      if (ins_valid != '0) begin k_vld = k; r_vld = ins_valid; r_word = ins_to_apctrl; end
      else if (ins_to_apctrl != '0) bad_data = 1;
      ins_reading = 1'b0; flush = 1'b0;
      if (ins_valid != '0 || ins_end) begin
        done = 1;
      end else begin
        if (ins_read_req && !accepted && $urandom_range(0, 1) == 1) begin
          ins_reading = 1'b1; accepted = 1;
          build_burst(base, len);
        end
        if (accepted && pend.size() > 0 && $urandom_range(0, 2) != 0) begin
          q.push_back(pend.pop_front()); pushed++;
        end
        if (inj_flush && pushed >= 3 && !flushed) begin flush = 1'b1; flushed = 1; end
        if (inj_rst && pushed >= 5) begin
          rst = 1'b1; ins_reading = 1'b0; flush = 1'b0;
          step(); step();
          chk("rst_read_req", 64'(ins_read_req), 64'd0);
          chk("rst_rd_en", 64'(rd_en_ddr_to_ic_fifo), 64'd0);
          chk("rst_valid", 64'(ins_valid), 64'd0);
          chk("rst_end", 64'(ins_end), 64'd0);
          chk("rst_data", 64'(ins_to_apctrl), 64'd0);
          rst = 1'b0;
          // DDR side is reset alongside the cache
          q.delete(); pend.delete();
          step();
          chk("rst_rdy", 64'(ins_cache_rdy), 64'd1);
          chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
          foreach (mv[i]) mv[i] = 0;
          m_miss = 0;
          return;
        end
        step();
        k++;
      end
    end
    chk("done", 64'(done), 64'd1);

    if (oor) begin
      chk("oor_end", 64'(cnt_end), 64'd1);
      chk("oor_no_valid", 64'(k_vld), 64'd0);
      chk("oor_no_req", 64'(got_req), 64'd0);
    end else begin
      chk("vld_val", 64'(r_vld), 64'hF);
      chk("word", 64'(r_word), 64'(prog[a]));
      chk("miss_req", 64'(got_req), 64'(!hit));
      if (hit) begin
        chk("hit_lat", 64'(k_vld), 64'd2);
      end else begin
        chk("rd_addr", 64'(r_addr), 64'(base << 3));
        chk("rd_len", 64'(r_len), 64'(len));
        m_miss++;
        if (flushed) foreach (mv[i]) mv[i] = 0;
        mv[line] = !flushed;
        mt[line] = tg;
      end
    end
    chk("no_stray_data", 64'(bad_data), 64'd0);
    step();
    pend.delete();
    chk("vld_pulse", 64'(ins_valid), 64'd0);
    chk("end_pulse", 64'(ins_end), 64'd0);
    chk("rdy_after", 64'(ins_cache_rdy), 64'd1);
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
  endtask

  initial begin
    rst = 1'b1; ins_req = 1'b0; addr_ins = '0; flush = 1'b0; ins_reading = 1'b0;
    ins_fifo_to_ic = '0; ddr_to_ic_fifo_empty = 1'b1;
    for (int i = 0; i < TOT; i++) prog[i] = IW'($urandom);
    foreach (mv[i]) begin mv[i] = 0; mt[i] = 0; end
    m_miss = 0;
    step(); step(); step();
    chk("init_read_req", 64'(ins_read_req), 64'd0);
    chk("init_rd_en", 64'(rd_en_ddr_to_ic_fifo), 64'd0);
    chk("init_valid", 64'(ins_valid), 64'd0);
    chk("init_end", 64'(ins_end), 64'd0);
    chk("init_data", 64'(ins_to_apctrl), 64'd0);
    rst = 1'b0;
    step();
    chk("init_rdy", 64'(ins_cache_rdy), 64'd1);
    chk("init_miss_cnt", 64'(miss_cnt), 64'd0);

    fetch(5, 0, 0);    // cold miss
    fetch(6, 0, 0);    // hit
    fetch(97, 0, 0);   // truncated last line
    fetch(133, 0, 0);  // beyond program end
    fetch(5, 0, 0);
    fetch(100, 0, 0);  // first out-of-range address
    fetch(40, 1, 0);   // flush while filling
    fetch(41, 0, 0);   // must miss after the flush
    fetch(70, 0, 1);   // reset mid-fill
    fetch(41, 0, 0);   // must miss after the reset
    for (int n = 0; n < 40; n++)
      fetch(int'($urandom_range(0, 140)), ($urandom_range(0, 7) == 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
